// File: rtl/dispatch_packet_sched_pkg.sv
// rtl/dispatch_packet_sched_pkg.sv - shared state type and width helpers for the packet scheduler
package dispatch_packet_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_e;

  // Index width that never collapses to zero bits for single-entry ranges
  function automatic int clog2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_num_packets(input int threads, input int lanes);
    return threads / lanes;
  endfunction

  function automatic int calc_pid_width(input int packets);
    return (packets > 1) ? $clog2(packets) : 1;
  endfunction

endpackage

// File: rtl/dispatch_packet_sched_if.sv
// rtl/dispatch_packet_sched_if.sv - issue-slot and packet-output bundle of the packet scheduler
interface dispatch_packet_sched_if
  import dispatch_packet_sched_pkg::*;
#(
  parameter int ISSUE_WIDTH = 4,
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 4
) ();

  localparam int SEL_WIDTH = clog2up(ISSUE_WIDTH);
  localparam int PID_WIDTH = calc_pid_width(calc_num_packets(NUM_THREADS, NUM_LANES));

  logic [ISSUE_WIDTH-1:0]             in_valid;
  logic [ISSUE_WIDTH*NUM_THREADS-1:0] in_tmask;
  logic [ISSUE_WIDTH-1:0]             in_ready;
  logic                               out_valid;
  logic                               out_ready;
  logic [SEL_WIDTH-1:0]               out_sel;
  logic [PID_WIDTH-1:0]               out_pid;
  logic [NUM_LANES-1:0]               out_lane_mask;
  logic                               out_sop;
  logic                               out_eop;

  modport master (
    output in_valid, in_tmask, out_ready,
    input  in_ready, out_valid, out_sel, out_pid, out_lane_mask, out_sop, out_eop
  );

  modport slave (
    input  in_valid, in_tmask, out_ready,
    output in_ready, out_valid, out_sel, out_pid, out_lane_mask, out_sop, out_eop
  );

endinterface

// File: rtl/dispatch_rr_pick.sv
// rtl/dispatch_rr_pick.sv - combinational round-robin picker: first request at or after start_ptr, wrapping
module dispatch_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start_ptr,
  input  logic [N-1:0]     exclude_mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0] cand;

  assign cand = req & ~exclude_mask;

  // Scan farthest-first so the candidate nearest start_ptr is written last and wins
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[(int'(start_ptr) + k) % N]) begin
        idx = IDX_W'((int'(start_ptr) + k) % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dispatch_packet_sched.sv
// rtl/dispatch_packet_sched.sv - grants an issue slot round-robin and splits its tmask into non-empty lane packets
module dispatch_packet_sched
  import dispatch_packet_sched_pkg::*;
#(
  parameter int ISSUE_WIDTH = 4,
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  dispatch_packet_sched_if.slave  bus
);

  localparam int NUM_PACKETS = calc_num_packets(NUM_THREADS, NUM_LANES);
  localparam int PID_WIDTH   = calc_pid_width(NUM_PACKETS);
  localparam int SEL_WIDTH   = clog2up(ISSUE_WIDTH);

  sched_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [PID_WIDTH-1:0]   pid_q, pid_d;
  logic                   sop_q, sop_d;
  logic [NUM_THREADS-1:0] tmask_q, tmask_d;

  logic                   busy;
  logic                   fire;
  logic                   eop;
  logic [PID_WIDTH-1:0]   next_pid;
  logic [SEL_WIDTH-1:0]   pick_start;
  logic [SEL_WIDTH-1:0]   pick_idx;
  logic                   pick_any;
  logic [ISSUE_WIDTH-1:0] pick_excl;
  logic [ISSUE_WIDTH-1:0] sel_onehot;
  logic [NUM_THREADS-1:0] grant_tmask;

  function automatic logic [SEL_WIDTH-1:0] wrap_inc(input logic [SEL_WIDTH-1:0] s);
    return (ISSUE_WIDTH == 1) ? '0 : s + 1'b1;
  endfunction

  // Lowest packet with any thread set; an all-zero warp still goes out once as packet 0
  function automatic logic [PID_WIDTH-1:0] first_pid(input logic [NUM_THREADS-1:0] m);
    logic [PID_WIDTH-1:0] r;
    r = '0;
    for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
      if (|m[p*NUM_LANES +: NUM_LANES]) r = PID_WIDTH'(p);
    end
    return r;
  endfunction

  always_comb begin
    next_pid = pid_q;
    eop      = 1'b1;
    for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
      if (p > int'(pid_q) && |tmask_q[p*NUM_LANES +: NUM_LANES]) begin
        next_pid = PID_WIDTH'(p);
        eop      = 1'b0;
      end
    end
  end

  assign busy       = (state_q == BUSY);
  assign fire       = busy & bus.out_ready;
  assign sel_onehot = ISSUE_WIDTH'(1) << sel_q;

  // One picker serves both the idle grant and the eop re-grant, which never coincide
  assign pick_start = busy ? wrap_inc(sel_q) : rr_ptr_q;
  assign pick_excl  = busy ? sel_onehot : '0;

  dispatch_rr_pick #(
    .N     (ISSUE_WIDTH),
    .IDX_W (SEL_WIDTH)
  ) u_pick (
    .req          (bus.in_valid),
    .start_ptr    (pick_start),
    .exclude_mask (pick_excl),
    .idx          (pick_idx),
    .any          (pick_any)
  );

  assign grant_tmask = bus.in_tmask[pick_idx*NUM_THREADS +: NUM_THREADS];

  assign bus.out_valid     = busy;
  assign bus.out_sel       = busy ? sel_q : '0;
  assign bus.out_pid       = busy ? pid_q : '0;
  assign bus.out_lane_mask = busy ? tmask_q[pid_q*NUM_LANES +: NUM_LANES] : '0;
  assign bus.out_sop       = busy & sop_q;
  assign bus.out_eop       = busy & eop;
  assign bus.in_ready      = (fire & eop) ? sel_onehot : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    pid_d    = pid_q;
    sop_d    = sop_q;
    tmask_d  = tmask_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          sel_d   = pick_idx;
          tmask_d = grant_tmask;
          pid_d   = first_pid(grant_tmask);
          sop_d   = 1'b1;
        end
      end
      BUSY: begin
        if (fire && !eop) begin
          pid_d = next_pid;
          sop_d = 1'b0;
        end else if (fire) begin
          rr_ptr_d = wrap_inc(sel_q);
          sop_d    = 1'b1;
          if (pick_any) begin
            sel_d   = pick_idx;
            tmask_d = grant_tmask;
            pid_d   = first_pid(grant_tmask);
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      pid_q    <= '0;
      sop_q    <= 1'b1;
      tmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      pid_q    <= pid_d;
      sop_q    <= sop_d;
      tmask_q  <= tmask_d;
    end
  end

endmodule

// File: tb/tb_dispatch_packet_sched.sv
// tb/tb_dispatch_packet_sched.sv - bench for dispatch_packet_sched against a packet-list model
module tb_dispatch_packet_sched;

  localparam int IW = 4;
  localparam int NT = 8;
  localparam int NL = 4;
  localparam int NP = NT / NL;

  logic clk;
  logic reset_n;

  int vectors = 0;
  int errors  = 0;

  dispatch_packet_sched_if #(.ISSUE_WIDTH(IW), .NUM_THREADS(NT), .NUM_LANES(NL)) bus ();

  dispatch_packet_sched #(
    .ISSUE_WIDTH (IW),
    .NUM_THREADS (NT),
    .NUM_LANES   (NL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Warp model: the granted slot plus the list of packet indices still to be sent
  bit            m_busy;
  int            m_slot;
  int            m_rr;
  bit            m_first;
  logic [NT-1:0] m_tmask;
  int            m_pkts[$];
  logic [IW-1:0] m_acked;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_slot  = 0;
    m_rr    = 0;
    m_first = 1'b1;
    m_tmask = '0;
    m_pkts.delete();
    m_acked = '0;
  endtask

  task automatic model_grant(input int start, input int excl);
    for (int k = 0; k < IW; k++) begin
      int s;
      s = (start + k) % IW;
      if (s != excl && bus.in_valid[s]) begin
        m_slot  = s;
        m_tmask = bus.in_tmask[s*NT +: NT];
        m_pkts.delete();
        for (int p = 0; p < NP; p++)
          if (m_tmask[p*NL +: NL] != '0) m_pkts.push_back(p);
        if (m_pkts.size() == 0) m_pkts.push_back(0);
        m_first = 1'b1;
        m_busy  = 1'b1;
        return;
      end
    end
  endtask

  task automatic model_step();
    m_acked = '0;
    if (m_busy && bus.out_ready) begin
      void'(m_pkts.pop_front());
      m_first = 1'b0;
      if (m_pkts.size() == 0) begin
        m_acked[m_slot] = 1'b1;
        m_rr   = (m_slot + 1) % IW;
        m_busy = 1'b0;
        model_grant(m_rr, m_slot);
      end
    end else if (!m_busy) begin
      model_grant(m_rr, -1);
    end
  endtask

  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  initial begin : compare_proc
    int            e_pid;
    logic [NL-1:0] e_lane;
    logic [IW-1:0] e_rdy;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_sel", 32'(bus.out_sel), 32'd0);
        chk("rst_out_pid", 32'(bus.out_pid), 32'd0);
        chk("rst_lane_mask", 32'(bus.out_lane_mask), 32'd0);
        chk("rst_sop_eop", 32'({bus.out_sop, bus.out_eop}), 32'd0);
      end else begin
        e_pid  = (m_pkts.size() > 0) ? m_pkts[0] : 0;
        e_lane = m_tmask[e_pid*NL +: NL];
        e_rdy  = '0;
        if (m_busy && bus.out_ready && m_pkts.size() == 1) e_rdy[m_slot] = 1'b1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_busy));
        chk("in_ready", 32'(bus.in_ready), 32'(e_rdy));
        if (m_busy) begin
          chk("out_sel", 32'(bus.out_sel), 32'(m_slot));
          chk("out_pid", 32'(bus.out_pid), 32'(e_pid));
          chk("out_lane_mask", 32'(bus.out_lane_mask), 32'(e_lane));
          chk("out_sop", 32'(bus.out_sop), 32'(m_first));
          chk("out_eop", 32'(bus.out_eop), 32'(m_pkts.size() == 1));
        end
      end
    end
  end

  task automatic set_tmask(input int s, input logic [NT-1:0] m);
    bus.in_tmask[s*NT +: NT] = m;
  endtask

  function automatic logic [NT-1:0] rand_mask();
    logic [31:0] r;
    r = $urandom;
    case (r[9:8])
      2'd0:    return 8'h00;
      2'd1:    return {r[3:0], 4'h0};
      2'd2:    return {4'h0, r[3:0]};
      default: return r[7:0];
    endcase
  endfunction

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while ((m_busy || bus.in_valid != '0) && n < 64) begin
      @(negedge clk);
      bus.in_valid &= ~m_acked;
      n++;
    end
    chk("drain_timeout", 32'(n < 64), 32'd1);
  endtask

  initial begin : main_proc
    int pulses;
    reset_n       = 1'b0;
    bus.in_valid  = '0;
    bus.in_tmask  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Full warp on slot 0: two packets, ack on the second
    @(negedge clk);
    bus.out_ready = 1'b1;
    set_tmask(0, 8'hFF);
    bus.in_valid = 4'b0001;
    #3 chk("t1_latency_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #3;
    chk("t1_p0_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_p0_pid", 32'(bus.out_pid), 32'd0);
    chk("t1_p0_sop_eop", 32'({bus.out_sop, bus.out_eop}), 32'b10);
    chk("t1_p0_lane", 32'(bus.out_lane_mask), 32'hF);
    chk("t1_p0_ready", 32'(bus.in_ready), 32'b0000);
    @(negedge clk);
    #3;
    chk("t1_p1_pid", 32'(bus.out_pid), 32'd1);
    chk("t1_p1_sop_eop", 32'({bus.out_sop, bus.out_eop}), 32'b01);
    chk("t1_p1_ready", 32'(bus.in_ready), 32'b0001);
    drain();

    // Empty low packet is skipped
    @(negedge clk);
    set_tmask(2, 8'hF0);
    bus.in_valid = 4'b0100;
    @(negedge clk);
    #3;
    chk("t2_skip_pid", 32'(bus.out_pid), 32'd1);
    chk("t2_skip_sop_eop", 32'({bus.out_sop, bus.out_eop}), 32'b11);
    chk("t2_skip_lane", 32'(bus.out_lane_mask), 32'hF);
    chk("t2_skip_ready", 32'(bus.in_ready), 32'b0100);
    drain();

    // All-zero warp still goes out once
    @(negedge clk);
    set_tmask(3, 8'h00);
    bus.in_valid = 4'b1000;
    @(negedge clk);
    #3;
    chk("t2_zero_sel", 32'(bus.out_sel), 32'd3);
    chk("t2_zero_pid", 32'(bus.out_pid), 32'd0);
    chk("t2_zero_sop_eop", 32'({bus.out_sop, bus.out_eop}), 32'b11);
    chk("t2_zero_lane", 32'(bus.out_lane_mask), 32'h0);
    chk("t2_zero_ready", 32'(bus.in_ready), 32'b1000);
    drain();

    // Round-robin with all slots valid: 0,1,2,3,0 with no bubble
    @(negedge clk);
    for (int s = 0; s < IW; s++) set_tmask(s, 8'hFF);
    bus.in_valid = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      for (int p = 0; p < 2; p++) begin
        @(negedge clk);
        #3;
        chk("t3_rr_valid", 32'(bus.out_valid), 32'd1);
        if (p == 0) chk("t3_rr_sel", 32'(bus.out_sel), 32'(w % IW));
      end
    end
    drain();

    // Backpressure at pid1 for five cycles, then exactly one ack
    @(negedge clk);
    set_tmask(1, 8'hFF);
    bus.in_valid = 4'b0010;
    @(negedge clk);
    #3 chk("t4_p0_pid", 32'(bus.out_pid), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #3;
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_pid", 32'(bus.out_pid), 32'd1);
      chk("t4_hold_lane", 32'(bus.out_lane_mask), 32'hF);
      chk("t4_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      #3;
      if (bus.in_ready != '0) pulses++;
      @(negedge clk);
      bus.in_valid &= ~m_acked;
    end
    chk("t4_ack_pulses", 32'(pulses), 32'd1);
    drain();

    // Asynchronous reset mid-warp on slot 2
    @(negedge clk);
    set_tmask(2, 8'hFF);
    bus.in_valid = 4'b0100;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #3;
    chk("t5_pre_sel", 32'(bus.out_sel), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_async_ready", 32'(bus.in_ready), 32'd0);
    chk("t5_async_sel", 32'(bus.out_sel), 32'd0);
    chk("t5_async_pid", 32'(bus.out_pid), 32'd0);
    chk("t5_async_lane", 32'(bus.out_lane_mask), 32'd0);
    chk("t5_async_sop_eop", 32'({bus.out_sop, bus.out_eop}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    set_tmask(0, 8'h3C);
    bus.in_valid  = 4'b0101;
    #3 chk("t5_rel_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #3;
    chk("t5_rr0_sel", 32'(bus.out_sel), 32'd0);
    chk("t5_rr0_lane", 32'(bus.out_lane_mask), 32'hC);
    chk("t5_rr0_sop", 32'(bus.out_sop), 32'd1);
    @(negedge clk);
    @(negedge clk);
    bus.in_valid &= ~m_acked;
    #3;
    chk("t5_s2_sel", 32'(bus.out_sel), 32'd2);
    chk("t5_s2_pid", 32'(bus.out_pid), 32'd0);
    chk("t5_s2_sop", 32'(bus.out_sop), 32'd1);
    drain();

    // Acked slot is excluded from the same-cycle re-grant
    @(negedge clk);
    set_tmask(1, 8'h0F);
    bus.in_valid = 4'b0010;
    @(negedge clk);
    #3;
    chk("t6_ack_ready", 32'(bus.in_ready), 32'b0010);
    chk("t6_ack_eop", 32'(bus.out_eop), 32'd1);
    @(negedge clk);
    bus.in_valid = 4'b0000;
    #3 chk("t6_idle_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #3 chk("t6_idle_valid2", 32'(bus.out_valid), 32'd0);

    // Randomized traffic under the hold-until-ack contract
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < IW; i++) begin
        if (bus.in_valid[i] && m_acked[i]) begin
          if ($urandom_range(1, 0) == 0) bus.in_valid[i] = 1'b0;
          else set_tmask(i, rand_mask());
        end else if (!bus.in_valid[i] && $urandom_range(2, 0) == 0) begin
          set_tmask(i, rand_mask());
          bus.in_valid[i] = 1'b1;
        end
      end
      bus.out_ready = ($urandom_range(3, 0) != 0);
      if (c == 1500) begin
        #3 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_packet_sched.md
Name: dispatch_packet_sched

Overview:
- Scheduler in front of the per-unit dispatch datapath.
- Each cycle it arbitrates round-robin among ISSUE_WIDTH issue slots and locks onto the winning slot.
- It sequences that slot's NUM_THREADS-wide tmask into NUM_LANES-wide packets, skipping all-zero packets, and emits select/pid/sop/eop to the datapath mux.
- It acknowledges the issue slot only when the eop packet is accepted.

Parameters:
- ISSUE_WIDTH, 4: number of issue slots; power of 2, >=1.
- NUM_THREADS, 8: threads per warp.
- NUM_LANES, 4: lanes per execute packet; must divide NUM_THREADS.
- NUM_PACKETS, NUM_THREADS/NUM_LANES: derived; do not override.
- PID_WIDTH, max(1, clog2(NUM_PACKETS)): derived.

Ports:
- clk, input, 1: clock.
- reset_n, input, 1: asynchronous active-low reset.
- in_valid, input, ISSUE_WIDTH: per-slot request.
- in_tmask, input, ISSUE_WIDTH*NUM_THREADS: per-slot thread mask; slot i occupies bits [i*NUM_THREADS +: NUM_THREADS].
- in_ready, output, ISSUE_WIDTH: one-hot slot acknowledge.
- out_valid, output, 1: packet valid.
- out_ready, input, 1: downstream accepts the packet.
- out_sel, output, clog2up(ISSUE_WIDTH): granted slot index.
- out_pid, output, PID_WIDTH: packet index.
- out_lane_mask, output, NUM_LANES: tmask slice of the current packet.
- out_sop, output, 1: first emitted packet of the warp.
- out_eop, output, 1: last emitted packet of the warp.

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-low.
- On reset assertion, all state clears immediately: state=IDLE, rr_ptr=0, sel=0, pid=0, sop_flag=1, tmask_q=0. Outputs are 0 while in reset: out_valid=0, in_ready=0, out_sel=0, out_pid=0, out_lane_mask=0, out_sop=0, out_eop=0. Any packet in flight is dropped and the slot is not acknowledged.
- Input contract: in_valid[i] and in_tmask slice i are held stable until in_ready[i]. The block does not check this.
- Arbitration: from IDLE, pick the first set in_valid at or after rr_ptr, with wrap-around. Grant is registered: the packet appears on out_* the cycle after in_valid is seen in IDLE. Minimum latency is 1 cycle.
- On grant, latch sel and tmask_q. pid = index of the first non-zero packet. If the whole tmask is 0, pid=0 and the warp is emitted as a single sop+eop packet.
- State IDLE:
  - out_valid=0.
  - Any in_valid set -> BUSY.
- State BUSY:
  - out_valid=1, out_sel=sel, out_pid=pid.
  - out_lane_mask = tmask_q[pid*NUM_LANES +: NUM_LANES].
  - out_sop = sop_flag.
  - out_eop = 1 when no non-zero packet exists above pid, or when the tmask is all zero.
- Fire condition: out_valid && out_ready.
  - Fire and not eop: pid <- next non-zero packet index (skip empties), sop_flag <- 0.
  - Fire and eop:
    - in_ready[sel]=1 combinationally in the same cycle. in_ready is 0 at all other times.
    - rr_ptr <- sel+1, mod ISSUE_WIDTH.
    - sop_flag <- 1.
    - Back-to-back: re-arbitrate this cycle over in_valid with bit sel masked off, starting at sel+1. If there is a winner, stay BUSY with the new grant latched (no bubble). Otherwise -> IDLE.
- out_ready low in BUSY: all outputs hold.
- out_valid never drops without a fire, except on reset.
- Skip logic: the next non-zero packet comes from a priority encode of the per-packet OR-reduced masks above pid. Widths wrap to PID_WIDTH with no overflow, since pid < NUM_PACKETS always.
- NUM_PACKETS=1: pid is constant 0, and every packet has sop=eop=1.
- ISSUE_WIDTH=1: out_sel is 0-width-safe (clog2up yields 1) and rr_ptr is constant 0.
- Fairness: a continuously valid slot is granted within ISSUE_WIDTH grants.

Decomposition:
- Shared package entries: NUM_PACKETS/PID_WIDTH derivation functions and the state enum (IDLE, BUSY).
- One natural sub-module: dispatch_rr_pick. It is a combinational round-robin priority picker with inputs req, start_ptr and exclude_mask, and outputs idx and any. It is used for both IDLE grant and eop re-grant.
- The rest (pid sequencer, skip encoder) stays inline.

Test Plan:
- Single slot, tmask=8'hFF, defaults, out_ready=1: 2 packets. pid0 sop=1 eop=0 lane_mask=F, then pid1 sop=0 eop=1. in_ready=4'b0001 on the 2nd packet. First packet appears 1 cycle after in_valid.
- Skip: tmask=8'hF0 -> 1 packet, pid=1, sop=eop=1, lane_mask=F. tmask=8'h00 -> 1 packet, pid=0, sop=eop=1, lane_mask=0.
- Round-robin: in_valid=4'b1111 held, each slot re-asserted after its ack, all tmasks FF. Grant order 0,1,2,3,0. No idle cycle between warps (out_valid continuously 1).
- Backpressure: out_ready=0 for 5 cycles mid-warp at pid1. out_valid, pid and lane_mask stay stable. Exactly one in_ready pulse after out_ready rises.
- Async reset: reset_n low mid-warp at pid0 of slot 2. All outputs 0 immediately without a clock edge. After release with slot 2 still valid, the grant restarts at pid0 with sop=1 and rr_ptr=0 order.
- Exclusion on re-grant: only slot 1 valid and in_valid[1] stays high for one cycle after its eop ack (it drops the next cycle). No duplicate grant of slot 1; the block returns to IDLE.
